load_align_unit: RTL and testbench

- Read-side counterpart of the data-memory store path.
- Accepts a load request (address, width, signedness) from the MEM stage and drives the data-memory read port (DM_addr/DM_oe).
- Extracts the addressed byte/half/word from DM_dataout, sign- or zero-extends it, and returns a registered result with a valid pulse.
- Loads that cross a word boundary are serviced with two sequential word reads, merged in the block.

---
 rtl/load_align_unit.sv | 129 ++++++++++++
 tb/tb_load_align_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Load path of the data-memory interface: issues one or two word reads per load,
// extracts the addressed byte/half/word and returns a sign/zero-extended result.
module load_align_unit #(
  parameter int unsigned ALLOW_MISALIGNED = 1,
  parameter logic [2:0]  WHB_WORD         = 3'b001,
  parameter logic [2:0]  WHB_HALF         = 3'b010,
  parameter logic [2:0]  WHB_BYTE         = 3'b100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  MemWHB,
  input  logic        ld_unsigned,
  output logic        ld_ready,
  output logic [31:0] DM_addr,
  output logic        DM_oe,
  input  logic [31:0] DM_dataout,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        ld_misalign
);

  typedef enum logic [1:0] {S_IDLE, S_RD0, S_RD1, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  whb_q;
  logic        uns_q;
  logic [31:0] w0_q, w0_d;
  logic [31:0] data_q, data_d;
  logic        mis_q, mis_d;
  logic [31:0] dm_addr_q;

  logic [31:0] word_addr;
  logic [1:0]  off;
  logic        split;
  logic        accept;

  assign word_addr = {addr_q[31:2], 2'b00};
  assign off       = addr_q[1:0];
  assign split     = ((whb_q == WHB_WORD) && (off != 2'b00)) ||
                     ((whb_q == WHB_HALF) && (off == 2'b11));
  assign accept    = ld_req && (state_q == S_IDLE) && !rst;

  // v = {w1,w0} >> 8*off, then pick width and extend.
  function automatic logic [31:0] extract(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [1:0] o, input logic [2:0] whb,
                                          input logic uns);
    logic [63:0] v;
    v = {w1, w0} >> {o, 3'b000};
    if (whb == WHB_BYTE)      extract = {{24{~uns & v[7]}}, v[7:0]};
    else if (whb == WHB_HALF) extract = {{16{~uns & v[15]}}, v[15:0]};
    else if (whb == WHB_WORD) extract = v[31:0];
    else                      extract = '0;
  endfunction

  always_comb begin
    state_d = state_q;
    DM_oe   = 1'b0;
    DM_addr = dm_addr_q;
    w0_d    = w0_q;
    data_d  = data_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          DM_oe   = 1'b1;
          DM_addr = {ld_addr[31:2], 2'b00};
          mis_d   = 1'b0;
          state_d = S_RD0;
        end
      end
      S_RD0: begin
        w0_d = DM_dataout;
        if (split && (ALLOW_MISALIGNED != 0)) begin
          DM_oe   = 1'b1;
          DM_addr = word_addr + 32'd4;
          state_d = S_RD1;
        end else begin
          data_d  = split ? '0 : extract(DM_dataout, '0, off, whb_q, uns_q);
          mis_d   = split;
          state_d = S_DONE;
        end
      end
      S_RD1: begin
        data_d  = extract(w0_q, DM_dataout, off, whb_q, uns_q);
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Reset outranks any read issued from the current state.
    if (rst) begin
      DM_oe   = 1'b0;
      DM_addr = dm_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      whb_q     <= '0;
      uns_q     <= 1'b0;
      w0_q      <= '0;
      data_q    <= '0;
      mis_q     <= 1'b0;
      dm_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      w0_q      <= w0_d;
      data_q    <= data_d;
      mis_q     <= mis_d;
      dm_addr_q <= DM_addr;
      if (accept) begin
        addr_q <= ld_addr;
        whb_q  <= MemWHB;
        uns_q  <= ld_unsigned;
      end
    end
  end

  assign ld_ready    = (state_q == S_IDLE);
  assign ld_valid    = (state_q == S_DONE);
  assign ld_data     = data_q;
  assign ld_misalign = mis_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench: one unit with misaligned splitting enabled and one with it disabled,
// each backed by its own synchronous memory model.
module tb_load_align_unit;

  localparam logic [2:0] C_WORD = 3'b001;
  localparam logic [2:0] C_HALF = 3'b010;
  localparam logic [2:0] C_BYTE = 3'b100;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [2:0]  whb;
  logic        uns;
  logic        req      [2];
  logic        ld_ready [2];
  logic [31:0] dm_addr  [2];
  logic        dm_oe    [2];
  logic [31:0] dm_dout  [2];
  logic [31:0] ld_data  [2];
  logic        ld_valid [2];
  logic        ld_mis   [2];

  int checks;
  int failures;

  load_align_unit #(.ALLOW_MISALIGNED(1), .WHB_WORD(C_WORD), .WHB_HALF(C_HALF), .WHB_BYTE(C_BYTE)) u_split (
    .clk(clk), .rst(rst), .ld_req(req[0]), .ld_addr(addr), .MemWHB(whb), .ld_unsigned(uns),
    .ld_ready(ld_ready[0]), .DM_addr(dm_addr[0]), .DM_oe(dm_oe[0]), .DM_dataout(dm_dout[0]),
    .ld_data(ld_data[0]), .ld_valid(ld_valid[0]), .ld_misalign(ld_mis[0]));

  load_align_unit #(.ALLOW_MISALIGNED(0), .WHB_WORD(C_WORD), .WHB_HALF(C_HALF), .WHB_BYTE(C_BYTE)) u_nosplit (
    .clk(clk), .rst(rst), .ld_req(req[1]), .ld_addr(addr), .MemWHB(whb), .ld_unsigned(uns),
    .ld_ready(ld_ready[1]), .DM_addr(dm_addr[1]), .DM_oe(dm_oe[1]), .DM_dataout(dm_dout[1]),
    .ld_data(ld_data[1]), .ld_valid(ld_valid[1]), .ld_misalign(ld_mis[1]));

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_rd = 32'h8899AABB;
      32'h0000_0104: mem_rd = 32'h11223344;
      32'hFFFF_FFFC: mem_rd = 32'hCAFEF00D;
      32'h0000_0000: mem_rd = 32'h01020304;
      default:       mem_rd = 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) if (dm_oe[0]) dm_dout[0] <= mem_rd(dm_addr[0]);
  always @(posedge clk) if (dm_oe[1]) dm_dout[1] <= mem_rd(dm_addr[1]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one load on unit d and checks the full cycle-by-cycle response.
  task automatic run_load(input int d, input string tag, input logic [31:0] a, input logic [2:0] w,
                          input logic u, input bit two_reads, input logic [31:0] exp_d,
                          input logic exp_m);
    int lat;
    logic [31:0] wa;
    logic [31:0] wa_next;
    lat     = two_reads ? 3 : 2;
    wa      = {a[31:2], 2'b00};
    wa_next = wa + 32'd4;
    @(posedge clk); #1;
    addr = a; whb = w; uns = u; req[d] = 1'b1;
    @(negedge clk);
    check({tag, ":T.ready"}, ld_ready[d], 1);
    check({tag, ":T.oe"}, dm_oe[d], 1);
    check({tag, ":T.addr"}, dm_addr[d], wa);
    @(posedge clk); #1;
    req[d] = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, ":T1.mis_clr"}, ld_mis[d], 0);
        check({tag, ":T1.oe"}, dm_oe[d], two_reads);
        if (two_reads) check({tag, ":T1.addr"}, dm_addr[d], wa_next);
      end else begin
        check($sformatf("%s:T%0d.oe", tag, c), dm_oe[d], 0);
      end
      check($sformatf("%s:T%0d.valid", tag, c), ld_valid[d], (c == lat));
      if (c == lat) begin
        check({tag, ":data"}, ld_data[d], exp_d);
        check({tag, ":mis"}, ld_mis[d], exp_m);
        check({tag, ":busy"}, ld_ready[d], 0);
      end
      if (c == lat + 1) begin
        check({tag, ":hold"}, ld_data[d], exp_d);
        check({tag, ":idle"}, ld_ready[d], 1);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; addr = '0; whb = '0; uns = 1'b0; req[0] = 1'b0; req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d.ready", d), ld_ready[d], 1);
      check($sformatf("rst%0d.valid", d), ld_valid[d], 0);
      check($sformatf("rst%0d.data", d), ld_data[d], 0);
      check($sformatf("rst%0d.mis", d), ld_mis[d], 0);
      check($sformatf("rst%0d.oe", d), dm_oe[d], 0);
      check($sformatf("rst%0d.addr", d), dm_addr[d], 0);
    end

    run_load(0, "LB101",  32'h101, C_BYTE, 1'b0, 1'b0, 32'hFFFFFFAA, 1'b0);
    run_load(0, "LHU102", 32'h102, C_HALF, 1'b1, 1'b0, 32'h00008899, 1'b0);
    run_load(0, "LH102",  32'h102, C_HALF, 1'b0, 1'b0, 32'hFFFF8899, 1'b0);
    run_load(0, "LW103",  32'h103, C_WORD, 1'b0, 1'b1, 32'h22334488, 1'b0);
    run_load(0, "LH103",  32'h103, C_HALF, 1'b0, 1'b1, 32'h00004488, 1'b0);
    run_load(0, "LW100",  32'h100, C_WORD, 1'b0, 1'b0, 32'h8899AABB, 1'b0);
    run_load(0, "LBU103", 32'h103, C_BYTE, 1'b1, 1'b0, 32'h00000088, 1'b0);
    run_load(0, "LB104",  32'h104, C_BYTE, 1'b0, 1'b0, 32'h00000044, 1'b0);
    run_load(0, "LH106",  32'h106, C_HALF, 1'b0, 1'b0, 32'h00001122, 1'b0);
    run_load(0, "LH102s", 32'h102, C_HALF, 1'b0, 1'b0, 32'hFFFF8899, 1'b0);
    run_load(0, "BADWHB", 32'h100, 3'b111, 1'b0, 1'b0, 32'h00000000, 1'b0);
    run_load(0, "LWwrap", 32'hFFFFFFFE, C_WORD, 1'b0, 1'b1, 32'h0304CAFE, 1'b0);
    run_load(1, "NS.LH103", 32'h103, C_HALF, 1'b0, 1'b0, 32'h00000000, 1'b1);
    run_load(1, "NS.LW100", 32'h100, C_WORD, 1'b0, 1'b0, 32'h8899AABB, 1'b0);
    run_load(1, "NS.LW102", 32'h102, C_WORD, 1'b0, 1'b0, 32'h00000000, 1'b1);
    run_load(1, "NS.LB103", 32'h103, C_BYTE, 1'b0, 1'b0, 32'hFFFFFF88, 1'b0);

    // ld_req held through the busy cycles
    @(posedge clk); #1;
    addr = 32'h100; whb = C_BYTE; uns = 1'b0; req[0] = 1'b1;
    @(negedge clk);
    check("busy:T.oe", dm_oe[0], 1);
    check("busy:T.addr", dm_addr[0], 32'h100);
    @(posedge clk); #1;
    addr = 32'h104;
    @(negedge clk);
    check("busy:T1.ready", ld_ready[0], 0);
    check("busy:T1.oe", dm_oe[0], 0);
    @(negedge clk);
    check("busy:T2.ready", ld_ready[0], 0);
    check("busy:T2.oe", dm_oe[0], 0);
    check("busy:T2.valid", ld_valid[0], 1);
    check("busy:T2.data", ld_data[0], 32'hFFFFFFBB);
    @(negedge clk);
    check("busy:T3.ready", ld_ready[0], 1);
    check("busy:T3.oe", dm_oe[0], 1);
    check("busy:T3.addr", dm_addr[0], 32'h104);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    check("busy:T4.oe", dm_oe[0], 0);
    check("busy:T4.valid", ld_valid[0], 0);
    @(negedge clk);
    check("busy:T5.valid", ld_valid[0], 1);
    check("busy:T5.data", ld_data[0], 32'h00000044);
    @(negedge clk);

    // reset during the second read of a split LW
    @(posedge clk); #1;
    addr = 32'h103; whb = C_WORD; uns = 1'b0; req[0] = 1'b1;
    @(negedge clk);
    check("rstRD1:T.oe", dm_oe[0], 1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    check("rstRD1:T1.oe", dm_oe[0], 1);
    check("rstRD1:T1.addr", dm_addr[0], 32'h104);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstRD1:ready", ld_ready[0], 1);
    check("rstRD1:oe", dm_oe[0], 0);
    check("rstRD1:addr", dm_addr[0], 0);
    check("rstRD1:data", ld_data[0], 0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("rstRD1:novalid%0d", c), ld_valid[0], 0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
